// File: rtl/npu_core.sv
// npu_core: instruction-driven NPU with one matrix-vector unit and two lane-wise
// vector function units. Every instruction takes exactly three cycles: fetch, decode, execute.

module npu_core #(
   parameter int OPCODE_WIDTH     = 4,
   parameter int TARGET_OP_WIDTH  = 3,
   parameter int VRF_AWIDTH       = 6,
   parameter int DRAM_AWIDTH      = 6,
   parameter int INSTR_MEM_AWIDTH = 10,
   parameter int NUM_LDPES        = 8,
   parameter int PRECISION        = 8,
   parameter int VRF_DWIDTH       = NUM_LDPES * PRECISION,
   parameter int INSTR_WIDTH      = OPCODE_WIDTH + 2 * TARGET_OP_WIDTH + 3 * VRF_AWIDTH
) (
   input  logic                        clk,
   input  logic                        reset_npu,
   input  logic [INSTR_WIDTH-1:0]      instruction,
   input  logic [VRF_DWIDTH-1:0]       input_data_DRAM,
   output logic [VRF_DWIDTH-1:0]       output_data_DRAM,
   output logic [DRAM_AWIDTH-1:0]      dram_addr,
   output logic                        dram_write_enable,
   output logic                        get_instr,
   output logic [INSTR_MEM_AWIDTH-1:0] get_instr_addr
);

   localparam int VRF_DEPTH = 1 << VRF_AWIDTH;

   localparam int DA_LSB  = 0;
   localparam int DID_LSB = DA_LSB + VRF_AWIDTH;
   localparam int OP2_LSB = DID_LSB + TARGET_OP_WIDTH;
   localparam int OP1_LSB = OP2_LSB + VRF_AWIDTH;
   localparam int SRC_LSB = OP1_LSB + VRF_AWIDTH;
   localparam int OPC_LSB = SRC_LSB + TARGET_OP_WIDTH;

   localparam logic [1:0] S_FETCH  = 2'd0;
   localparam logic [1:0] S_DECODE = 2'd1;
   localparam logic [1:0] S_EXEC   = 2'd2;
   localparam logic [1:0] S_HALT   = 2'd3;

   localparam logic [OPCODE_WIDTH-1:0] OP_V_RD      = OPCODE_WIDTH'(1);
   localparam logic [OPCODE_WIDTH-1:0] OP_V_WR      = OPCODE_WIDTH'(2);
   localparam logic [OPCODE_WIDTH-1:0] OP_M_RD      = OPCODE_WIDTH'(3);
   localparam logic [OPCODE_WIDTH-1:0] OP_MV_MUL    = OPCODE_WIDTH'(4);
   localparam logic [OPCODE_WIDTH-1:0] OP_VV_ADD    = OPCODE_WIDTH'(5);
   localparam logic [OPCODE_WIDTH-1:0] OP_VV_MUL    = OPCODE_WIDTH'(6);
   localparam logic [OPCODE_WIDTH-1:0] OP_END_CHAIN = OPCODE_WIDTH'(7);

   localparam logic [TARGET_OP_WIDTH-1:0] ID_MVU  = TARGET_OP_WIDTH'(0);
   localparam logic [TARGET_OP_WIDTH-1:0] ID_MFU0 = TARGET_OP_WIDTH'(1);
   localparam logic [TARGET_OP_WIDTH-1:0] ID_MFU1 = TARGET_OP_WIDTH'(2);

   logic [1:0]                  state;
   logic [INSTR_MEM_AWIDTH-1:0] pc;
   logic [INSTR_WIDTH-1:0]      instr_q;

   logic [OPCODE_WIDTH-1:0]     opcode;
   logic [TARGET_OP_WIDTH-1:0]  src_id;
   logic [TARGET_OP_WIDTH-1:0]  dstn_id;
   logic [VRF_AWIDTH-1:0]       op1_addr;
   logic [VRF_AWIDTH-1:0]       op2_addr;
   logic [VRF_AWIDTH-1:0]       dstn_addr;

   logic [VRF_DWIDTH-1:0] vrf0 [VRF_DEPTH];
   logic [VRF_DWIDTH-1:0] vrf1 [VRF_DEPTH];
   logic [VRF_DWIDTH-1:0] vrf2 [VRF_DEPTH];
   logic [VRF_DWIDTH-1:0] mrf  [NUM_LDPES][VRF_DEPTH];

   logic [VRF_DWIDTH-1:0]      src_a;
   logic [VRF_DWIDTH-1:0]      src_b;
   logic [VRF_DWIDTH-1:0]      mvu_result;
   logic                       exec_active;
   logic                       vrf_we;
   logic [TARGET_OP_WIDTH-1:0] vrf_wid;
   logic [VRF_AWIDTH-1:0]      vrf_waddr;
   logic [VRF_DWIDTH-1:0]      vrf_wdata;
   logic                       mrf_we;

   assign opcode    = instr_q[OPC_LSB +: OPCODE_WIDTH];
   assign src_id    = instr_q[SRC_LSB +: TARGET_OP_WIDTH];
   assign op1_addr  = instr_q[OP1_LSB +: VRF_AWIDTH];
   assign op2_addr  = instr_q[OP2_LSB +: VRF_AWIDTH];
   assign dstn_id   = instr_q[DID_LSB +: TARGET_OP_WIDTH];
   assign dstn_addr = instr_q[DA_LSB +: VRF_AWIDTH];

   // Only the low PRECISION bits of any lane result are kept, so products and
   // the dot-product accumulation can wrap at lane width without changing them.
   function automatic logic [PRECISION-1:0] lane_dot(input logic [VRF_DWIDTH-1:0] v,
                                                      input logic [VRF_DWIDTH-1:0] m);
      logic [PRECISION-1:0] acc;
      logic [PRECISION-1:0] prod;
      acc = '0;
      for (int j = 0; j < NUM_LDPES; j++) begin
         prod = v[j*PRECISION +: PRECISION] * m[j*PRECISION +: PRECISION];
         acc  = acc + prod;
      end
      return acc;
   endfunction

   function automatic logic [VRF_DWIDTH-1:0] lane_add(input logic [VRF_DWIDTH-1:0] a,
                                                      input logic [VRF_DWIDTH-1:0] b);
      logic [VRF_DWIDTH-1:0] r;
      r = '0;
      for (int i = 0; i < NUM_LDPES; i++)
         r[i*PRECISION +: PRECISION] = a[i*PRECISION +: PRECISION] + b[i*PRECISION +: PRECISION];
      return r;
   endfunction

   function automatic logic [VRF_DWIDTH-1:0] lane_mul(input logic [VRF_DWIDTH-1:0] a,
                                                      input logic [VRF_DWIDTH-1:0] b);
      logic [VRF_DWIDTH-1:0] r;
      r = '0;
      for (int i = 0; i < NUM_LDPES; i++)
         r[i*PRECISION +: PRECISION] = a[i*PRECISION +: PRECISION] * b[i*PRECISION +: PRECISION];
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (reset_npu) begin
         state   <= S_FETCH;
         pc      <= '0;
         instr_q <= '0;
      end else begin
         case (state)
            S_FETCH:  state <= S_DECODE;
            S_DECODE: begin
               instr_q <= instruction;
               state   <= S_EXEC;
            end
            S_EXEC: begin
               pc    <= pc + 1'b1;
               state <= (opcode == OP_END_CHAIN) ? S_HALT : S_FETCH;
            end
            S_HALT:   state <= S_HALT;
            default:  state <= S_FETCH;
         endcase
      end
   end

   assign get_instr      = (state == S_FETCH) && !reset_npu;
   assign get_instr_addr = reset_npu ? '0 : pc;
   assign exec_active    = (state == S_EXEC) && !reset_npu;

   always_comb begin
      src_a = '0;
      src_b = '0;
      case (src_id)
         ID_MVU: begin
            src_a = vrf0[op1_addr];
            src_b = vrf0[op2_addr];
         end
         ID_MFU0: begin
            src_a = vrf1[op1_addr];
            src_b = vrf1[op2_addr];
         end
         ID_MFU1: begin
            src_a = vrf2[op1_addr];
            src_b = vrf2[op2_addr];
         end
         default: ;
      endcase
   end

   // Each matrix bank holds one row, so lane i of the result comes from bank i.
   always_comb begin
      mvu_result = '0;
      for (int i = 0; i < NUM_LDPES; i++)
         mvu_result[i*PRECISION +: PRECISION] = lane_dot(vrf0[op1_addr], mrf[i][op1_addr]);
   end

   always_comb begin
      output_data_DRAM  = '0;
      dram_addr         = '0;
      dram_write_enable = 1'b0;
      vrf_we            = 1'b0;
      vrf_wid           = dstn_id;
      vrf_waddr         = dstn_addr;
      vrf_wdata         = '0;
      mrf_we            = 1'b0;
      if (exec_active) begin
         case (opcode)
            OP_V_RD: begin
               dram_addr = op2_addr;
               vrf_we    = 1'b1;
               vrf_wid   = src_id;
               vrf_waddr = op1_addr;
               vrf_wdata = input_data_DRAM;
            end
            OP_V_WR: begin
               dram_addr         = op2_addr;
               output_data_DRAM  = src_a;
               dram_write_enable = 1'b1;
            end
            OP_M_RD: begin
               dram_addr = op2_addr;
               mrf_we    = 1'b1;
            end
            OP_MV_MUL: begin
               vrf_we    = 1'b1;
               vrf_wdata = mvu_result;
            end
            OP_VV_ADD: begin
               vrf_we    = 1'b1;
               vrf_wdata = lane_add(src_a, src_b);
            end
            OP_VV_MUL: begin
               vrf_we    = 1'b1;
               vrf_wdata = lane_mul(src_a, src_b);
            end
            default: ;
         endcase
      end
   end

   // Register files are never cleared; an unknown target id simply drops the write.
   always_ff @(posedge clk) begin
      if (vrf_we) begin
         case (vrf_wid)
            ID_MVU:  vrf0[vrf_waddr] <= vrf_wdata;
            ID_MFU0: vrf1[vrf_waddr] <= vrf_wdata;
            ID_MFU1: vrf2[vrf_waddr] <= vrf_wdata;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (mrf_we)
         mrf[src_id][op1_addr] <= input_data_DRAM;
   end

endmodule

// File: tb/tb_npu_core.sv
// tb_npu_core: drives npu_core with directed and random programs and checks
// fetch timing, DRAM traffic and final DRAM contents against a lane-level model.

module tb_npu_core;

   logic        clk = 1'b0;
   logic        reset_npu = 1'b0;
   logic [27:0] instruction = '0;
   logic [63:0] input_data_DRAM;
   logic [63:0] output_data_DRAM;
   logic [5:0]  dram_addr;
   logic        dram_write_enable;
   logic        get_instr;
   logic [9:0]  get_instr_addr;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [63:0] dram [64];
   logic [27:0] imem [1024];

   logic [63:0] m_dram [64];
   logic [63:0] m_vrf  [3][64];
   logic [63:0] m_mrf  [8][64];

   logic [27:0] prog [$];
   logic [69:0] exp_wr [$];
   logic [69:0] obs_wr [$];
   int          last_writes;

   always #5 clk = ~clk;

   npu_core dut (
      .clk               (clk),
      .reset_npu         (reset_npu),
      .instruction       (instruction),
      .input_data_DRAM   (input_data_DRAM),
      .output_data_DRAM  (output_data_DRAM),
      .dram_addr         (dram_addr),
      .dram_write_enable (dram_write_enable),
      .get_instr         (get_instr),
      .get_instr_addr    (get_instr_addr)
   );

   // External memories: DRAM reads combinationally, instruction memory has one cycle of latency.
   assign input_data_DRAM = dram[dram_addr];

   always @(posedge clk) begin
      if (dram_write_enable === 1'b1)
         dram[dram_addr] = output_data_DRAM;
      if (get_instr === 1'b1)
         instruction <= imem[get_instr_addr];
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [27:0] mk(input int op, input int src, input int o1,
                                      input int o2, input int dst, input int da);
      logic [27:0] w;
      w = {4'(op), 3'(src), 6'(o1), 6'(o2), 3'(dst), 6'(da)};
      return w;
   endfunction

   function automatic int lane_s(input logic [63:0] v, input int j);
      logic signed [7:0] b;
      b = v[j*8 +: 8];
      return int'(b);
   endfunction

   function automatic logic [63:0] splat(input logic [7:0] b);
      return {8{b}};
   endfunction

   task automatic set_dram(input int addr, input logic [63:0] val);
      dram[addr]   = val;
      m_dram[addr] = val;
   endtask

   // Reference behaviour: one instruction applied to the model state, lane arithmetic on plain ints.
   task automatic model_exec(input logic [27:0] ins, output bit halt);
      int op, src, o1, o2, dst, da, s;
      logic [63:0] a, b, r;
      op  = int'(ins[27:24]);
      src = int'(ins[23:21]);
      o1  = int'(ins[20:15]);
      o2  = int'(ins[14:9]);
      dst = int'(ins[8:6]);
      da  = int'(ins[5:0]);
      halt = 1'b0;
      r = '0;
      a = (src < 3) ? m_vrf[src][o1] : 64'd0;
      b = (src < 3) ? m_vrf[src][o2] : 64'd0;
      case (op)
         1: if (src < 3) m_vrf[src][o1] = m_dram[o2];
         2: begin
            exp_wr.push_back({6'(o2), a});
            m_dram[o2] = a;
         end
         3: m_mrf[src][o1] = m_dram[o2];
         4: begin
            for (int i = 0; i < 8; i++) begin
               s = 0;
               for (int j = 0; j < 8; j++)
                  s += lane_s(m_vrf[0][o1], j) * lane_s(m_mrf[i][o1], j);
               r[i*8 +: 8] = 8'(s);
            end
            if (dst < 3) m_vrf[dst][da] = r;
         end
         5, 6: begin
            for (int i = 0; i < 8; i++)
               r[i*8 +: 8] = (op == 5) ? 8'(lane_s(a, i) + lane_s(b, i))
                                       : 8'(lane_s(a, i) * lane_s(b, i));
            if (dst < 3) m_vrf[dst][da] = r;
         end
         7: halt = 1'b1;
         default: ;
      endcase
   endtask

   task automatic load_imem;
      for (int i = 0; i < 1024; i++)
         imem[i] = (i < prog.size()) ? prog[i] : 28'd0;
   endtask

   task automatic reset_pulse;
      int bad;
      bad = 0;
      @(posedge clk);
      #1 reset_npu = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         if ({get_instr, get_instr_addr, dram_write_enable, dram_addr, output_data_DRAM} !== 82'd0)
            bad++;
         @(posedge clk);
      end
      #1 reset_npu = 1'b0;
      tests_run++;
      if (bad !== 0) begin
         tests_failed++;
         $display("[TB] FAIL reset_outputs: %0d cycles with nonzero outputs, want 0", bad);
      end
   endtask

   task automatic run_program(input string name, input int extra);
      int  n, bad_fetch, bad_addr, bad_idle, bad_wr, bad_mem;
      bit  halted;
      bit  exp_get;
      exp_wr.delete();
      obs_wr.delete();
      load_imem();
      n = 0;
      halted = 1'b0;
      while (!halted && n < prog.size()) begin
         model_exec(prog[n], halted);
         n++;
      end
      reset_pulse();
      bad_fetch = 0; bad_addr = 0; bad_idle = 0;
      for (int c = 0; c < 3 * n + extra; c++) begin
         @(negedge clk);
         exp_get = (c < 3 * n) && (c % 3 == 0);
         if (get_instr !== exp_get) bad_fetch++;
         if (get_instr === 1'b1 && get_instr_addr !== 10'(c / 3)) bad_addr++;
         if (!(c < 3 * n && c % 3 == 2) &&
             {dram_write_enable, dram_addr, output_data_DRAM} !== 71'd0) bad_idle++;
         if (dram_write_enable === 1'b1) obs_wr.push_back({dram_addr, output_data_DRAM});
         @(posedge clk);
      end
      #1;
      last_writes = obs_wr.size();
      tests_run++;
      if (bad_fetch !== 0) begin
         tests_failed++;
         $display("[TB] FAIL %s fetch_timing: %0d bad cycles, want 0", name, bad_fetch);
      end
      tests_run++;
      if (bad_addr !== 0) begin
         tests_failed++;
         $display("[TB] FAIL %s fetch_addr: %0d bad fetch addresses, want 0", name, bad_addr);
      end
      tests_run++;
      if (bad_idle !== 0) begin
         tests_failed++;
         $display("[TB] FAIL %s idle_outputs: %0d bad cycles, want 0", name, bad_idle);
      end
      tests_run++;
      if (obs_wr.size() !== exp_wr.size()) begin
         tests_failed++;
         $display("[TB] FAIL %s write_count: got %0d want %0d", name, obs_wr.size(), exp_wr.size());
      end else begin
         bad_wr = 0;
         for (int i = 0; i < obs_wr.size(); i++)
            if (obs_wr[i] !== exp_wr[i]) bad_wr++;
         tests_run++;
         if (bad_wr !== 0) begin
            tests_failed++;
            $display("[TB] FAIL %s write_data: %0d wrong writes, first got %h want %h",
                     name, bad_wr, obs_wr[0], exp_wr[0]);
         end
      end
      bad_mem = 0;
      for (int i = 0; i < 64; i++)
         if (dram[i] !== m_dram[i]) bad_mem++;
      tests_run++;
      if (bad_mem !== 0) begin
         tests_failed++;
         $display("[TB] FAIL %s dram_contents: %0d words differ, want 0", name, bad_mem);
      end
   endtask

   task automatic check_word(input string name, input int addr, input logic [63:0] want);
      tests_run++;
      if (dram[addr] !== want) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h want %h", name, dram[addr], want);
      end
   endtask

   task automatic test_reset;
      prog = {mk(7, 0, 0, 0, 0, 0)};
      run_program("reset_end_chain", 20);
   endtask

   task automatic test_init_storage;
      prog.delete();
      for (int id = 0; id < 3; id++)
         for (int a = 0; a < 16; a++)
            prog.push_back(mk(1, id, a, $urandom_range(0, 63), 0, 0));
      for (int bk = 0; bk < 8; bk++)
         for (int a = 0; a < 16; a++)
            prog.push_back(mk(3, bk, a, $urandom_range(0, 63), 0, 0));
      prog.push_back(mk(7, 0, 0, 0, 0, 0));
      run_program("init_storage", 3);
   endtask

   task automatic test_vrd_vwr;
      set_dram(5, 64'h0101010101010101);
      prog = {mk(1, 1, 3, 5, 0, 0), mk(2, 1, 3, 9, 0, 0), mk(7, 0, 0, 0, 0, 0)};
      run_program("vrd_vwr", 3);
      check_word("vrd_vwr_dram9", 9, 64'h0101010101010101);
      tests_run++;
      if (last_writes !== 1) begin
         tests_failed++;
         $display("[TB] FAIL vrd_vwr_we_cycles: got %0d want 1", last_writes);
      end
   endtask

   task automatic test_mv_mul;
      set_dram(10, splat(8'h01));
      prog.delete();
      for (int bk = 0; bk < 8; bk++) prog.push_back(mk(3, bk, 2, 10, 0, 0));
      prog.push_back(mk(1, 0, 2, 10, 0, 0));
      prog.push_back(mk(4, 0, 2, 0, 1, 0));
      prog.push_back(mk(2, 1, 0, 40, 0, 0));
      prog.push_back(mk(7, 0, 0, 0, 0, 0));
      run_program("mv_mul", 3);
      check_word("mv_mul_result", 40, splat(8'h08));
   endtask

   task automatic test_vector_ops;
      set_dram(11, splat(8'h7F));
      set_dram(12, splat(8'h02));
      set_dram(13, splat(8'hFF));
      set_dram(14, splat(8'h03));
      prog = {mk(1, 1, 0, 11, 0, 0), mk(1, 1, 1, 12, 0, 0), mk(5, 1, 0, 1, 2, 4),
              mk(2, 2, 4, 41, 0, 0),
              mk(1, 2, 6, 13, 0, 0), mk(1, 2, 7, 14, 0, 0), mk(6, 2, 6, 7, 0, 8),
              mk(2, 0, 8, 42, 0, 0),
              mk(5, 2, 6, 7, 5, 4), mk(6, 2, 6, 7, 5, 8),
              mk(2, 2, 4, 43, 0, 0), mk(2, 0, 8, 44, 0, 0), mk(7, 0, 0, 0, 0, 0)};
      run_program("vector_ops", 3);
      check_word("vv_add_wrap", 41, splat(8'h81));
      check_word("vv_mul_neg", 42, splat(8'hFD));
      check_word("bad_dstn_vrf2", 43, splat(8'h81));
      check_word("bad_dstn_vrf0", 44, splat(8'hFD));
   endtask

   task automatic test_reset_abort;
      logic [63:0] keep51;
      bit found;
      set_dram(50, {$urandom, $urandom});
      prog = {mk(1, 1, 5, 50, 0, 0), mk(7, 0, 0, 0, 0, 0)};
      load_imem();
      reset_pulse();
      found = 1'b0;
      for (int c = 0; c < 12 && !found; c++) begin
         @(negedge clk);
         if (dram_addr === 6'd50) begin
            found = 1'b1;
            reset_npu = 1'b1;
            #1;
            tests_run++;
            if (dram_addr !== 6'd0) begin
               tests_failed++;
               $display("[TB] FAIL abort_vrd_addr: got %h want 00", dram_addr);
            end
         end
         @(posedge clk);
      end
      tests_run++;
      if (!found) begin
         tests_failed++;
         $display("[TB] FAIL abort_vrd_seen: got 0 want 1");
      end

      keep51 = dram[51];
      prog = {mk(2, 1, 5, 51, 0, 0), mk(7, 0, 0, 0, 0, 0)};
      load_imem();
      reset_pulse();
      found = 1'b0;
      for (int c = 0; c < 12 && !found; c++) begin
         @(negedge clk);
         if (dram_write_enable === 1'b1) begin
            found = 1'b1;
            reset_npu = 1'b1;
            #1;
            tests_run++;
            if (dram_write_enable !== 1'b0) begin
               tests_failed++;
               $display("[TB] FAIL abort_vwr_we: got %b want 0", dram_write_enable);
            end
         end
         @(posedge clk);
      end
      tests_run++;
      if (!found) begin
         tests_failed++;
         $display("[TB] FAIL abort_vwr_seen: got 0 want 1");
      end
      #1;
      check_word("abort_vwr_no_write", 51, keep51);
      reset_npu = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({get_instr, get_instr_addr} !== {1'b1, 10'd0}) begin
         tests_failed++;
         $display("[TB] FAIL abort_restart: got get_instr=%b addr=%0d want 1/0",
                  get_instr, get_instr_addr);
      end

      prog = {mk(2, 1, 5, 52, 0, 0), mk(7, 0, 0, 0, 0, 0)};
      run_program("abort_vrf_intact", 3);
   endtask

   task automatic test_random;
      int ops [13] = '{0, 1, 2, 3, 4, 5, 6, 2, 4, 5, 6, 9, 15};
      int op;
      for (int p = 0; p < 8; p++) begin
         prog.delete();
         for (int k = 0; k < 30; k++) begin
            op = ops[$urandom_range(0, 12)];
            prog.push_back(mk(op,
                              (op == 3) ? $urandom_range(0, 7) : $urandom_range(0, 3),
                              $urandom_range(0, 15),
                              (op == 5 || op == 6) ? $urandom_range(0, 15) : $urandom_range(0, 63),
                              $urandom_range(0, 3),
                              $urandom_range(0, 15)));
         end
         prog.push_back(mk(7, 0, 0, 0, 0, 0));
         run_program($sformatf("random_%0d", p), 4);
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) set_dram(i, {$urandom, $urandom});
      test_reset();
      test_init_storage();
      test_vrd_vwr();
      test_mv_mul();
      test_vector_ops();
      test_reset_abort();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
